i2c_master_arbiter: RTL and testbench
=====================================

// Module: i2c_master_arbiter
// PURPOSE
//  Shares one I2C master engine between NREQ requesters, one byte transaction at a time.
//  Round-robin arbitration; latches the winner's command; forwards it on a valid/ready port.
//  Waits for the engine's response and returns rdata/nack to the winner with a one-cycle done pulse.
//  Sits between the register-bus clients and the I2C master that drives SCL/SDA.
// PARAMETERS
//  NREQ            4     number of requesters (2..8); IDXW=$clog2(NREQ) is a localparam
//  TIMEOUT_CYCLES  1024  response watchdog limit, in clk cycles (used only with I2C_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  rst_n      in   1        asynchronous active-low reset
//  req        in   NREQ     per-requester request level; held until that requester's done
//  req_addr   in   NREQ*7   7-bit slave address, requester i at [7i+6:7i]
//  req_rw     in   NREQ     1 = read, 0 = write
//  req_wdata  in   NREQ*8   write byte, requester i at [8i+7:8i]
//  done       out  NREQ     one-cycle completion pulse, one-hot
//  rdata      out  8        read byte; valid with done
//  nack       out  1        slave NACK or timeout; valid with done
//  busy       out  1        high in every state except IDLE
//  cmd_valid  out  1        command to the master engine
//  cmd_ready  in   1        engine accepts the command
//  cmd_addr   out  7        latched address
//  cmd_rw     out  1        latched read/write bit
//  cmd_wdata  out  8        latched write byte
//  rsp_valid  in   1        engine transaction finished (one-cycle pulse)
//  rsp_rdata  in   8        engine read byte
//  rsp_nack   in   1        engine saw a NACK
//  abort      out  1        one-cycle pulse: engine must drop the bus (timeout build only)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, ptr=0, grant_idx=0, command latches=0.
//   All outputs 0; cmd_* and rdata also 0.
//  FSM states:
//   IDLE : if |req, pick the first set bit searching ptr, ptr+1, ... (mod NREQ).
//          Latch grant_idx and that requester's addr/rw/wdata; go to ISSUE. Otherwise stay.
//   ISSUE: cmd_valid=1 with the latched fields; fields stay stable while cmd_valid is high.
//          cmd_ready=1 -> WAIT.
//   WAIT : rsp_valid=1 -> latch rsp_rdata/rsp_nack, go to DONE.
//   DONE : done[grant_idx]=1 for exactly one cycle with rdata/nack valid.
//          ptr <= (grant_idx+1) mod NREQ; go to IDLE.
//  Latency: req sampled in IDLE at cycle N -> cmd_valid at N+1.
//   rsp_valid at cycle M -> done at M+1. Back-to-back grants are separated by one IDLE cycle.
//  req is sampled only in IDLE.
//   A req drop after grant is ignored; the transaction completes and done still pulses.
//   A requester must drop req in the cycle after its done, otherwise it is re-eligible.
//  rsp_valid outside WAIT is ignored.
//  rdata/nack hold their last values until the next DONE.
//  Single requester: served on every arbitration pass; ptr rotation gives no starvation.
//  Reset asserted mid-transaction: immediate return to the reset values.
//   No done pulse; the engine is reset by the same rst_n.
// CONFIGURATION
//  I2C_ARB_TIMEOUT_EN defined:
//   - A counter clears on entry to WAIT and increments every WAIT cycle.
//   - count == TIMEOUT_CYCLES-1 with no rsp_valid -> abort=1 for one cycle, then DONE with nack=1, rdata=0.
//   - rsp_valid in the same cycle as the timeout: the response wins, no abort.
//   - ISSUE has no timeout.
//  Not defined: the counter and abort logic are absent; abort is tied 0; WAIT can last indefinitely.
// TESTING
//  1. Single write: req=4'b0010, addr1=0x50, rw=0, wdata=0xA5; cmd_ready=1, rsp 5 cycles later, nack=0
//     -> cmd_addr=0x50, cmd_wdata=0xA5 at cycle+1; done=4'b0010 one cycle after rsp_valid.
//  2. All four requesting, reset ptr=0 -> grant order 0,1,2,3.
//     With req0 re-raised after its done: order 0,1,2,3,0.
//  3. Read with NACK: rsp_rdata=0x3C, rsp_nack=1 -> rdata=0x3C, nack=1 with done.
//     cmd_valid held 3 cycles while cmd_ready=0 with stable fields.
//  4. rst_n pulsed low in WAIT -> outputs 0 immediately, state IDLE, no done.
//     Next req is granted normally from ptr=0.
//  5. I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no rsp -> abort at WAIT cycle 16, then done, nack=1.
//     rsp_valid on cycle 16 instead -> no abort, nack=rsp_nack.
//  6. rsp_valid pulsed while in IDLE -> ignored; no done, rdata unchanged.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_master_arbiter
//
// Shares one I2C master engine between NREQ register-bus requesters, one byte
// transaction at a time. A round-robin pointer picks the next requester in
// IDLE. The winner's address/rw/write-byte are latched and offered to the
// engine on a valid/ready command port. The engine's response is then returned
// to the winner as a one-cycle one-hot done pulse, with rdata/nack valid.
//
// Optional feature macro: I2C_ARB_TIMEOUT_EN
//   When defined, a response watchdog runs in WAIT. After TIMEOUT_CYCLES WAIT
//   cycles without rsp_valid, abort pulses for one cycle and the transaction
//   completes with nack=1, rdata=0. When undefined, abort is tied low and WAIT
//   can last indefinitely.
//
// Parameters
//   NREQ            number of requesters (2..8)
//   TIMEOUT_CYCLES  watchdog limit in clk cycles (timeout build only)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req[NREQ]                  request levels, held until the matching done
//   req_addr[NREQ*7]           per-requester 7-bit slave address
//   req_rw[NREQ]               per-requester read(1)/write(0)
//   req_wdata[NREQ*8]          per-requester write byte
//   done[NREQ]                 one-hot completion pulse
//   rdata[8], nack             result of the last completed transaction
//   busy                       high whenever not IDLE
//   cmd_valid/cmd_ready        command handshake to the master engine
//   cmd_addr, cmd_rw, cmd_wdata latched command fields
//   rsp_valid, rsp_rdata, rsp_nack  engine response (one-cycle pulse)
//   abort                      engine must drop the bus (timeout build only)
// -----------------------------------------------------------------------------
module i2c_master_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*7-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              nack,
  output logic              busy,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [6:0]        cmd_addr,
  output logic              cmd_rw,
  output logic [7:0]        cmd_wdata,
  input  logic              rsp_valid,
  input  logic [7:0]        rsp_rdata,
  input  logic              rsp_nack,
  output logic              abort
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW:0]   NREQ_W = (IDXW+1)'(NREQ);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  // Elaboration-time parameter sanity check.
  generate
    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("i2c_master_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] grant_idx_q, grant_idx_d;
  logic [6:0]      addr_q, addr_d;
  logic            rw_q, rw_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            nack_q, nack_d;
  logic            timeout_hit;

  // Unpack the flat per-requester buses into arrays.
  logic [6:0] addr_arr  [NREQ];
  logic [7:0] wdata_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[7*gi +: 7];
      assign wdata_arr[gi] = req_wdata[8*gi +: 8];
    end
  endgenerate

  // Round-robin pick: first set req bit at ptr, ptr+1, ... (mod NREQ).
  // The loop runs from the farthest offset down so the nearest one wins.
  logic            found;
  logic [IDXW-1:0] pick;
  logic [IDXW:0]   rot_sum;

  always_comb begin
    found   = 1'b0;
    pick    = '0;
    rot_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rot_sum = {1'b0, ptr_q} + (IDXW+1)'(k);
      if (rot_sum >= NREQ_W) begin
        rot_sum = rot_sum - NREQ_W;
      end
      if (req[rot_sum[IDXW-1:0]]) begin
        found = 1'b1;
        pick  = rot_sum[IDXW-1:0];
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(TIMEOUT_CYCLES - 1);

  logic [CNTW-1:0] count_q, count_d;

  // A response arriving on the limit cycle takes priority over the timeout.
  assign timeout_hit = (state_q == S_WAIT) && (count_q == CNT_LIMIT) && !rsp_valid;
  assign abort       = timeout_hit;

  always_comb begin
    count_d = count_q;
    if (state_q == S_ISSUE && cmd_ready) begin
      count_d = '0;
    end else if (state_q == S_WAIT) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign abort       = 1'b0;
`endif

  // Next-state and latch logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    nack_d      = nack_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_idx_d = pick;
          addr_d      = addr_arr[pick];
          rw_d        = req_rw[pick];
          wdata_d     = wdata_arr[pick];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          rdata_d = rsp_rdata;
          nack_d  = rsp_nack;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          rdata_d = 8'h00;
          nack_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      nack_q      <= nack_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_done
      assign done[gi] = (state_q == S_DONE) && (grant_idx_q == IDXW'(gi));
    end
  endgenerate

  assign busy      = (state_q != S_IDLE);
  assign cmd_valid = (state_q == S_ISSUE);
  assign cmd_addr  = addr_q;
  assign cmd_rw    = rw_q;
  assign cmd_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign nack      = nack_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_master_arbiter
//
// Directed bench for i2c_master_arbiter (NREQ=4). Plays the master engine by
// hand: accepts commands, returns responses, and checks grants, latched
// command fields, done/rdata/nack, reset behaviour and (when built with
// I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) the watchdog.
// -----------------------------------------------------------------------------
module tb_i2c_master_arbiter;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*7-1:0] req_addr;
  logic [NREQ-1:0]   req_rw;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   done;
  logic [7:0]        rdata;
  logic              nack;
  logic              busy;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [6:0]        cmd_addr;
  logic              cmd_rw;
  logic [7:0]        cmd_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_nack;
  logic              abort;

  int n_checks = 0;
  int n_errors = 0;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  i2c_master_arbiter #(
    .NREQ          (NREQ),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .done      (done),
    .rdata     (rdata),
    .nack      (nack),
    .busy      (busy),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_rw    (cmd_rw),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nack  (rsp_nack),
    .abort     (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd_valid(input string tag);
    int n;
    n = 0;
    while (!cmd_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, cmd_valid, 1);
  endtask

  // Serve one transaction: accept the command, respond on the next cycle and
  // check the done pulse. Returns in the DONE cycle.
  task automatic serve(input string tag, input int exp_idx,
                       input logic [7:0] rd, input logic nk);
    wait_cmd_valid({tag, "_valid"});
    check({tag, "_addr"}, cmd_addr, 32'h10 + exp_idx);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = rd;
    rsp_nack  = nk;
    tick();
    rsp_valid = 1'b0;
    check({tag, "_done"}, done, 32'd1 << exp_idx);
    check({tag, "_rdata"}, rdata, rd);
    check({tag, "_nack"}, nack, nk);
    $display("txn %s: granted addr=0x%02h done=%b rdata=0x%02h nack=%0d",
             tag, cmd_addr, done, rdata, nack);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic early;
    rst_n     = 1'b0;
    req       = '0;
    req_rw    = '0;
    req_wdata = '0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_nack  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[7*i +: 7]  = 7'(8'h10 + i);
      req_wdata[8*i +: 8] = 8'(8'hB0 + i);
    end

    // Reset state.
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_done", done, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_abort", abort, 0);
    rst_n = 1'b1;
    tick();

    // 1. Single write from requester 1.
    req_addr[7 +: 7]  = 7'h50;
    req_wdata[8 +: 8] = 8'hA5;
    req_rw[1]         = 1'b0;
    req               = 4'b0010;
    cmd_ready         = 1'b1;
    tick();
    check("t1_cmd_valid", cmd_valid, 1);
    check("t1_cmd_addr", cmd_addr, 7'h50);
    check("t1_cmd_wdata", cmd_wdata, 8'hA5);
    check("t1_cmd_rw", cmd_rw, 0);
    tick();
    cmd_ready = 1'b0;
    check("t1_wait_valid", cmd_valid, 0);
    for (int i = 0; i < 4; i++) tick();
    rsp_valid = 1'b1;
    rsp_rdata = 8'h00;
    rsp_nack  = 1'b0;
    tick();
    rsp_valid = 1'b0;
    req       = '0;
    check("t1_done", done, 4'b0010);
    check("t1_nack", nack, 0);
    $display("txn t1: write addr=0x50 wdata=0xA5 done=%b nack=%0d", done, nack);
    tick();
    check("t1_done_one_cycle", done, 0);
    req_addr[7 +: 7] = 7'h11;

    // 2. Round-robin from ptr=0 with req0 kept high: 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    serve("t2_g0", 0, 8'h01, 1'b0);
    serve("t2_g1", 1, 8'h02, 1'b0);
    req[1] = 1'b0;
    serve("t2_g2", 2, 8'h03, 1'b0);
    req[2] = 1'b0;
    serve("t2_g3", 3, 8'h04, 1'b0);
    req[3] = 1'b0;
    serve("t2_g0b", 0, 8'h05, 1'b0);
    req[0] = 1'b0;
    tick();
    tick();
    check("t2_idle", busy, 0);

    // 3. Read with NACK, cmd_ready held low for 3 cycles.
    req_rw[2] = 1'b1;
    req       = 4'b0100;
    wait_cmd_valid("t3_valid");
    req_addr[14 +: 7] = 7'h7F;   // source change must not reach the latched command
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_valid", cmd_valid, 1);
      check("t3_hold_addr", cmd_addr, 7'h12);
      check("t3_hold_rw", cmd_rw, 1);
    end
    req_addr[14 +: 7] = 7'h12;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    req       = '0;              // drop after grant: transaction still completes
    rsp_valid = 1'b1;
    rsp_rdata = 8'h3C;
    rsp_nack  = 1'b1;
    tick();
    rsp_valid = 1'b0;
    check("t3_done", done, 4'b0100);
    check("t3_rdata", rdata, 8'h3C);
    check("t3_nack", nack, 1);
    $display("txn t3: read done=%b rdata=0x%02h nack=%0d", done, rdata, nack);
    tick();

    // 6. rsp_valid in IDLE is ignored.
    rsp_valid = 1'b1;
    rsp_rdata = 8'h77;
    rsp_nack  = 1'b0;
    tick();
    rsp_valid = 1'b0;
    tick();
    check("t6_done", done, 0);
    check("t6_rdata", rdata, 8'h3C);
    check("t6_nack", nack, 1);
    check("t6_busy", busy, 0);

    // 4. Reset asserted in WAIT.
    req = 4'b1000;
    wait_cmd_valid("t4_valid");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("t4_in_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_busy", busy, 0);
    check("t4_rst_rdata", rdata, 0);
    check("t4_rst_nack", nack, 0);
    check("t4_rst_cmd_addr", cmd_addr, 0);
    check("t4_rst_done", done, 0);
    #2;
    rst_n = 1'b1;
    req   = '0;
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      early = early | (|done);
    end
    check("t4_no_done", early, 0);
    req = 4'b1010;               // ptr restarted at 0 -> requester 1 first
    serve("t4_after", 1, 8'h9A, 1'b0);
    req = '0;
    tick();

    // 5. Response watchdog.
    req = 4'b0001;
    wait_cmd_valid("t5_valid");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    req       = '0;
`ifdef I2C_ARB_TIMEOUT_EN
    early = abort;               // WAIT cycle 1
    for (int i = 2; i <= 15; i++) begin
      tick();
      early = early | abort;
    end
    check("t5_no_early_abort", early, 0);
    tick();                      // WAIT cycle 16
    check("t5_abort", abort, 1);
    tick();
    check("t5_abort_pulse", abort, 0);
    check("t5_done", done, 4'b0001);
    check("t5_nack", nack, 1);
    check("t5_rdata", rdata, 0);
    $display("txn t5a: timeout done=%b nack=%0d rdata=0x%02h", done, nack, rdata);
    tick();
    req = 4'b0001;
    wait_cmd_valid("t5b_valid");
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    req       = '0;
    for (int i = 2; i <= 16; i++) tick();
    rsp_valid = 1'b1;            // response on the limit cycle wins
    rsp_rdata = 8'h5A;
    rsp_nack  = 1'b0;
    #1;
    check("t5b_no_abort", abort, 0);
    tick();
    rsp_valid = 1'b0;
    check("t5b_done", done, 4'b0001);
    check("t5b_nack", nack, 0);
    check("t5b_rdata", rdata, 8'h5A);
    $display("txn t5b: late response done=%b nack=%0d rdata=0x%02h", done, nack, rdata);
`else
    early = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      early = early | abort | (|done);
    end
    check("t5_no_abort", early, 0);
    check("t5_still_wait", busy, 1);
    rsp_valid = 1'b1;
    rsp_rdata = 8'h5A;
    rsp_nack  = 1'b0;
    tick();
    rsp_valid = 1'b0;
    check("t5_done", done, 4'b0001);
    check("t5_rdata", rdata, 8'h5A);
    $display("txn t5: long wait done=%b nack=%0d rdata=0x%02h", done, nack, rdata);
`endif
    tick();
    check("end_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
